// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial framing stages.
// Used by the deserializer and, later, the serializer.
package serdes_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DATA   = 2'd1;
  localparam state_t PARITY = 2'd2;
  localparam state_t STOP   = 2'd3;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bits needed to index n items (at least 1).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: new bits enter at the MSB,
// so after DATA_W shifts the first bit sits in bit 0.
module serial_shift_reg
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  generate
    if (DATA_W == 1) begin : g_one
      // Single-bit word: the register is the bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= din;
      end
    end else begin : g_many
      // Shift right, new bit at the top.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= {din, q[DATA_W-1:1]};
      end
    end
  endgenerate

endmodule

// File: rtl/serial_frame_deserializer.sv
// Frame receiver: start, data LSB first, optional parity,
// stop; one-entry valid/ready output buffer.
module serial_frame_deserializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              bit_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              par_bit;
  logic [DATA_W-1:0] sr_q;

  logic start_det;
  logic sr_en;
  logic stop_ok;
  logic stop_bad;
  logic consume;
  logic can_load;
  logic perr_now;

  assign start_det = bit_en && (state == IDLE)
                  && (din == START_BIT);
  assign sr_en     = bit_en && (state == DATA);
  assign stop_ok   = bit_en && (state == STOP)
                  && (din == STOP_BIT);
  assign stop_bad  = bit_en && (state == STOP)
                  && (din != STOP_BIT);
  assign consume   = dout_valid && dout_ready;
  assign can_load  = !dout_valid || dout_ready;
  assign perr_now  = PARITY_EN
                  && (par_bit != (^sr_q ^ PARITY_ODD));

  serial_shift_reg #(
    .DATA_W (DATA_W)
  ) u_sr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_det),
    .en    (sr_en),
    .din   (din),
    .q     (sr_q)
  );

  // Frame FSM; advances only on bit strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      par_bit <= 1'b0;
    end else if (bit_en) begin
      case (state)
        IDLE: begin
          if (din == START_BIT) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          par_bit <= din;
          state   <= STOP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_ok && !can_load;
      if (stop_ok && can_load) begin
        dout       <= sr_q;
        parity_err <= perr_now;
        dout_valid <= 1'b1;
      end else if (consume) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench with scoreboard for the frame receiver.
// DATA_W=8, even parity, strobe every 4th cycle.
module tb_serial_frame_deserializer;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       bit_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int tests;
  int fails;
  logic [8:0] sb[$];

  serial_frame_deserializer #(
    .DATA_W     (8),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .bit_en     (bit_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    logic [8:0] e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=word expected=none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_dout"}, 32'(dout), 32'(e[7:0]));
      chk({tag, "_perr"}, 32'(parity_err), 32'(e[8]));
    end
  endtask

  // One bit: 3 idle cycles, then bit_en high for one edge.
  task automatic strobe(input logic b, input logic r);
    @(negedge clk);
    bit_en = 1'b0;
    din    = b;
    repeat (2) @(negedge clk);
    @(negedge clk);
    bit_en     = 1'b1;
    dout_ready = r;
  endtask

  task automatic tick();
    @(negedge clk);
    bit_en = 1'b0;
  endtask

  // Returns with the stop strobe pending on the next edge.
  task automatic send_frame(input logic [7:0] d,
                            input logic pflip,
                            input logic stop,
                            input logic load,
                            input logic rdy_last);
    strobe(1'b0, dout_ready);
    for (int i = 0; i < 8; i++)
      strobe(d[i], dout_ready);
    strobe(^d ^ pflip, dout_ready);
    strobe(stop, rdy_last);
    if (stop && load) sb.push_back({pflip, d});
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    din        = 1'b1;
    bit_en     = 1'b0;
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal 0xA5 and latency.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("nom_pre_valid", 32'(dout_valid), 32'h0);
    tick();
    chk("nom_valid", 32'(dout_valid), 32'h1);
    chk_pop("nom");
    tick();
    chk("nom_drain", 32'(dout_valid), 32'h0);

    // Parity error is delivered, not dropped.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("par_valid", 32'(dout_valid), 32'h1);
    chk_pop("par");
    tick();

    // Framing error: single pulse, no word.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("fe_pulse", 32'(frame_err), 32'h1);
    chk("fe_valid", 32'(dout_valid), 32'h0);
    chk("fe_ovr", 32'(overrun), 32'h0);
    tick();
    chk("fe_end", 32'(frame_err), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fe_next_valid", 32'(dout_valid), 32'h1);
    chk_pop("fe_next");
    tick();

    // Overrun: 0x81 dropped while 0x3C pending.
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("ovr_valid1", 32'(dout_valid), 32'h1);
    chk_pop("ovr_first");
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_keep", 32'(dout), 32'h3C);
    chk("ovr_ferr", 32'(frame_err), 32'h0);
    tick();
    chk("ovr_end", 32'(overrun), 32'h0);
    chk("ovr_still", 32'(dout_valid), 32'h1);
    dout_ready = 1'b1;
    tick();
    chk("ovr_drain", 32'(dout_valid), 32'h0);
    chk("ovr_retain", 32'(dout), 32'h3C);
    chk("ovr_sb", 32'(sb.size()), 32'h0);

    // Consume and load in the same cycle.
    dout_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_pop("sim_first");
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("sim_ovr", 32'(overrun), 32'h0);
    chk("sim_valid", 32'(dout_valid), 32'h1);
    chk_pop("sim_second");
    tick();

    // Reset mid-frame, then gated din toggling.
    strobe(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) strobe(i[0], 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_dout", 32'(dout), 32'h0);
    chk("mid_valid", 32'(dout_valid), 32'h0);
    chk("mid_perr", 32'(parity_err), 32'h0);
    chk("mid_ferr", 32'(frame_err), 32'h0);
    chk("mid_ovr", 32'(overrun), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    din   = 1'b0;
    repeat (6) @(negedge clk);
    din = 1'b1;
    chk("gate_valid", 32'(dout_valid), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("post_valid", 32'(dout_valid), 32'h1);
    chk_pop("post");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
